ifelse_arbiter4: RTL

- Sequential four-way arbiter sharing a single resource between requesters a, b, c and d. Fixed priority is a > b > c > d.
- Selectable round-robin mode and a bounded hold time per grant.
- Drives a one-hot grant and an encoded select index. The index feeds the priority/select mux datapath downstream.
- Sits in front of that mux, replacing the combinational if-else priority choice with a registered, fair sequencer.

---
 rtl/ifelse_arbiter4.sv | 103 ++++++++++
 1 files changed

// File: rtl/ifelse_arbiter4.sv
// Registered four-way arbiter (a > b > c > d, or rotating) with a bounded hold
// per grant and a one-cycle turnaround gap between consecutive grants.
module ifelse_arbiter4 #(
    parameter int MAX_HOLD    = 8,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy,
    output logic       timeout
);
    localparam int NUM_REQ = 4;
    localparam int CW      = 8;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t          state, state_n;
    logic [3:0]      grant_n;
    logic [1:0]      idx_n, last, last_n, win, cand;
    logic [CW-1:0]   cnt, cnt_n;
    logic            to_n, found;

    // Scan order starts just past the previous winner in rotating mode.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ROUND_ROBIN ? last + 2'(k + 1) : 2'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        idx_n   = grant_idx;
        cnt_n   = cnt;
        last_n  = last;
        to_n    = 1'b0;
        case (state)
            IDLE, RELEASE: begin
                if (found) begin
                    state_n = GRANT;
                    grant_n = 4'b0001 << win;
                    idx_n   = win;
                    cnt_n   = CW'(1);
                end else begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
            GRANT: begin
                if (!req[grant_idx] || cnt == CW'(MAX_HOLD)) begin
                    state_n = RELEASE;
                    grant_n = '0;
                    last_n  = grant_idx;
                    cnt_n   = '0;
                    // Only a forced end counts as a timeout, not a withdrawal.
                    to_n    = req[grant_idx];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            cnt       <= '0;
            last      <= 2'd3;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            grant_idx <= idx_n;
            cnt       <= cnt_n;
            last      <= last_n;
            timeout   <= to_n;
        end
    end

    assign busy = |grant;

    a_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_busy:    assert property (@(posedge clk) disable iff (!rst_n) busy == |grant);
    a_idx:     assert property (@(posedge clk) disable iff (!rst_n) busy |-> grant[grant_idx]);
    a_to_once: assert property (@(posedge clk) disable iff (!rst_n) timeout |=> !timeout);

endmodule
